// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared skid-buffer state encoding and select-width helper
package mips_pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_t;
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_skid_nb_if.sv
// mux_skid_nb_if: handshake bus (in_data/sel/in_valid/in_ready/flush in, out_data/out_valid/out_ready/sel_err out); master = driver side, slave = buffer side
interface mux_skid_nb_if #(parameter int WIDTH = 5, parameter int NUM_IN = 2);
  import mips_pipe_pkg::*;
  localparam int SEL_W = sel_width(NUM_IN);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0] sel;
  logic in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [WIDTH-1:0] out_data;
  modport master(output in_data, sel, in_valid, flush, out_ready, input in_ready, out_data, out_valid, sel_err);
  modport slave(input in_data, sel, in_valid, flush, out_ready, output in_ready, out_data, out_valid, sel_err);
endinterface

// File: rtl/mux_nto1.sv
// mux_nto1: combinational NUM_IN:1 WIDTH-bit selector; data/sel in, y out (zero when out of range), bad flags sel >= NUM_IN
module mux_nto1 import mips_pipe_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 2,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y,
  output logic                    bad
);
  logic [WIDTH-1:0] slot [NUM_IN];
  for (genvar k = 0; k < NUM_IN; k++) begin : g_slot
    assign slot[k] = data[k*WIDTH +: WIDTH];
  end
  always_comb begin
    bad = int'(sel) >= NUM_IN;
    y = '0;
    for (int i = 0; i < NUM_IN; i++) y = (int'(sel) == i) ? slot[i] : y;
  end
endmodule

// File: rtl/mux_skid_nb.sv
// mux_skid_nb: N:1 select into a two-entry skid buffer; clk, rst_n (sync, active-low), bus.slave carries the valid/ready handshake, flush and sel_err
module mux_skid_nb import mips_pipe_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 2
) (
  input logic clk,
  input logic rst_n,
  mux_skid_nb_if.slave bus
);
  skid_state_t state;
  logic [WIDTH-1:0] main_q, skid_q, word;
  logic bad, acc, pop;
  mux_nto1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_sel (
    .data(bus.in_data), .sel(bus.sel), .y(word), .bad(bad)
  );
  assign bus.in_ready = state != TWO;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_data = main_q;
  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      bus.sel_err <= 1'b0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      if (acc && bad) bus.sel_err <= 1'b1;
      case (state)
        EMPTY: if (acc) begin
          state <= ONE;
          main_q <= word;
        end
        ONE: if (acc && !pop) begin
          state <= TWO;
          skid_q <= word;
        end else if (pop && !acc) begin
          state <= EMPTY;
        end else if (acc) begin
          main_q <= word;
        end
        TWO: if (pop) begin
          state <= ONE;
          main_q <= skid_q;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_skid_nb.sv
// tb_mux_skid_nb: directed vector table plus hand sequences for mux_skid_nb (NUM_IN=4 and NUM_IN=3 instances)
module tb_mux_skid_nb;
  logic clk = 1'b0;
  logic rn4, rn3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mux_skid_nb_if #(.WIDTH(5), .NUM_IN(4)) b4 ();
  mux_skid_nb_if #(.WIDTH(5), .NUM_IN(3)) b3 ();
  mux_skid_nb #(.WIDTH(5), .NUM_IN(4)) d4 (.clk(clk), .rst_n(rn4), .bus(b4));
  mux_skid_nb #(.WIDTH(5), .NUM_IN(3)) d3 (.clk(clk), .rst_n(rn3), .bus(b3));
  typedef struct {
    logic rn, v, f, r;
    logic [1:0] s;
    logic [19:0] d;
    logic ov, cd, ir, se;
    logic [4:0] od;
  } vec_t;
  vec_t tv[$];
  function automatic logic [19:0] put(input int k, input logic [4:0] w);
    logic [19:0] b;
    b = {5'd31, 5'd11, 5'd7, 5'd3};
    b[k*5 +: 5] = w;
    return b;
  endfunction
  function automatic vec_t mk(input logic rn, v, f, r, input logic [1:0] s, input logic [19:0] d,
                              input logic ov, cd, input logic [4:0] od, input logic ir, se);
    vec_t t;
    t.rn = rn; t.v = v; t.f = f; t.r = r; t.s = s; t.d = d;
    t.ov = ov; t.cd = cd; t.od = od; t.ir = ir; t.se = se;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive3(input logic rn, v, f, r, input logic [1:0] s);
    rn3 = rn; b3.in_valid = v; b3.flush = f; b3.out_ready = r; b3.sel = s;
  endtask
  localparam logic [19:0] BG = {5'd31, 5'd11, 5'd7, 5'd3};
  initial begin
    rn4 = 1'b0; rn3 = 1'b0;
    b4.in_data = BG; b4.sel = '0; b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b0;
    b3.in_data = {5'd9, 5'd6, 5'd4}; b3.sel = '0; b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b0;
    // reset held three cycles with a beat presented
    for (int i = 0; i < 3; i++) tv.push_back(mk(0, 1, 0, 1, 2'd1, BG, 0, 1, 5'd0, 1, 0));
    // streaming 3,7,11,31 then drain
    tv.push_back(mk(1, 1, 0, 1, 2'd0, BG, 1, 1, 5'd3, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 2'd1, BG, 1, 1, 5'd7, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 2'd2, BG, 1, 1, 5'd11, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 2'd3, BG, 1, 1, 5'd31, 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 2'd0, BG, 0, 0, 5'd0, 1, 0));
    // stall: 0x1A held, 0x05 skidded, 0x0C refused until release
    tv.push_back(mk(1, 1, 0, 0, 2'd1, put(1, 5'h1A), 1, 1, 5'h1A, 1, 0));
    tv.push_back(mk(1, 1, 0, 0, 2'd2, put(2, 5'h05), 1, 1, 5'h1A, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 2'd3, put(3, 5'h0C), 1, 1, 5'h1A, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 2'd3, put(3, 5'h0C), 1, 1, 5'h1A, 0, 0));
    tv.push_back(mk(1, 1, 0, 1, 2'd3, put(3, 5'h0C), 1, 1, 5'h05, 1, 0));
    tv.push_back(mk(1, 1, 0, 1, 2'd3, put(3, 5'h0C), 1, 1, 5'h0C, 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 2'd0, BG, 0, 0, 5'd0, 1, 0));
    // flush from TWO with a beat presented
    tv.push_back(mk(1, 1, 0, 0, 2'd0, BG, 1, 1, 5'd3, 1, 0));
    tv.push_back(mk(1, 1, 0, 0, 2'd1, BG, 1, 1, 5'd3, 0, 0));
    tv.push_back(mk(1, 1, 1, 0, 2'd2, BG, 0, 0, 5'd0, 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 2'd0, BG, 0, 0, 5'd0, 1, 0));
    // simultaneous accept+pop in state ONE for 10 cycles
    tv.push_back(mk(1, 1, 0, 1, 2'd0, BG, 1, 1, 5'd3, 1, 0));
    for (int k = 0; k < 10; k++)
      tv.push_back(mk(1, 1, 0, 1, 2'(k % 4), put(k % 4, 5'((k * 7 + 2) % 32)), 1, 1, 5'((k * 7 + 2) % 32), 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 2'd0, BG, 0, 0, 5'd0, 1, 0));
    // reset mid-operation discards the buffered beat
    tv.push_back(mk(1, 1, 0, 0, 2'd2, BG, 1, 1, 5'd11, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 2'd1, BG, 0, 1, 5'd0, 1, 0));
    tv.push_back(mk(1, 0, 0, 1, 2'd0, BG, 0, 0, 5'd0, 1, 0));
    foreach (tv[i]) begin
      rn4 = tv[i].rn; b4.in_valid = tv[i].v; b4.flush = tv[i].f; b4.out_ready = tv[i].r;
      b4.sel = tv[i].s; b4.in_data = tv[i].d;
      tick();
      chk($sformatf("row%0d out_valid", i), 32'(b4.out_valid), 32'(tv[i].ov));
      chk($sformatf("row%0d in_ready", i), 32'(b4.in_ready), 32'(tv[i].ir));
      chk($sformatf("row%0d sel_err", i), 32'(b4.sel_err), 32'(tv[i].se));
      if (tv[i].cd) chk($sformatf("row%0d out_data", i), 32'(b4.out_data), 32'(tv[i].od));
    end
    b4.in_valid = 1'b0;
    // NUM_IN=3: out-of-range select, sticky through flush, cleared by reset
    drive3(0, 0, 0, 1, 2'd0); tick(); tick();
    chk("n3 reset sel_err", 32'(b3.sel_err), 32'd0);
    drive3(1, 1, 0, 1, 2'd3); tick();
    chk("n3 bad out_valid", 32'(b3.out_valid), 32'd1);
    chk("n3 bad out_data", 32'(b3.out_data), 32'd0);
    chk("n3 bad sel_err", 32'(b3.sel_err), 32'd1);
    drive3(1, 1, 0, 1, 2'd2); tick();
    chk("n3 sel2 out_data", 32'(b3.out_data), 32'd9);
    chk("n3 sel2 sel_err", 32'(b3.sel_err), 32'd1);
    drive3(1, 1, 1, 1, 2'd1); tick();
    chk("n3 flush out_valid", 32'(b3.out_valid), 32'd0);
    chk("n3 flush sel_err", 32'(b3.sel_err), 32'd1);
    drive3(1, 0, 0, 1, 2'd0); tick();
    chk("n3 idle sel_err", 32'(b3.sel_err), 32'd1);
    drive3(0, 0, 0, 1, 2'd0); tick();
    chk("n3 rst sel_err", 32'(b3.sel_err), 32'd0);
    drive3(1, 1, 1, 1, 2'd3); tick();
    chk("n3 flushed bad sel_err", 32'(b3.sel_err), 32'd0);
    chk("n3 flushed bad out_valid", 32'(b3.out_valid), 32'd0);
    drive3(1, 0, 0, 1, 2'd0); tick();
    chk("n3 final sel_err", 32'(b3.sel_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
